// File: rtl/muldiv_iter_unit.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Build option MULDIV_FAST_MUL_EN selects a single-cycle multiplier for mul ops.
package muldiv_iter_pkg;
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_MUL_U = 4'd8,
      ALU_MUL_S = 4'd9,
      ALU_DIV_S = 4'd10,
      ALU_DIV_U = 4'd11,
      ALU_REM_S = 4'd12,
      ALU_REM_U = 4'd13
   } aluop_e;
endpackage

module muldiv_iter_unit
   import muldiv_iter_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  aluop_e          op_i,
   input  logic            mul_hi_i,
   input  logic            mulhsu_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              is_mul_q, is_mul_d;
   logic              hi_sel_q, hi_sel_d;
   logic              rem_sel_q, rem_sel_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;

   logic              op_mul_s, op_div_s, op_rem_s;
   logic              sgn_a_raw_s, sgn_b_raw_s, sgn_a_s, sgn_b_s;
   logic              neg_a_s, neg_b_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s;

   logic [XLEN:0]     mul_sum_s;
   logic [2*XLEN-1:0] mul_prod_s, mul_prod_sgn_s;
   logic [XLEN-1:0]   mul_res_s;
   logic [XLEN:0]     div_rem_sh_s, div_diff_s;
   logic              div_ge_s;
   logic [XLEN-1:0]   div_rem_s, div_quo_s, div_pick_s, div_res_s;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod_s, fast_prod_sgn_s;
   logic [XLEN-1:0]   fast_res_s;
`endif

   // Decode the offered op into kind and operand signedness.
   always_comb begin
      op_mul_s    = 1'b0;
      op_div_s    = 1'b0;
      op_rem_s    = 1'b0;
      sgn_a_raw_s = 1'b0;
      sgn_b_raw_s = 1'b0;
      case (op_i)
         ALU_MUL_U: op_mul_s = 1'b1;
         ALU_MUL_S: begin
            op_mul_s    = 1'b1;
            sgn_a_raw_s = 1'b1;
            sgn_b_raw_s = 1'b1;
         end
         ALU_DIV_S: begin
            op_div_s    = 1'b1;
            sgn_a_raw_s = 1'b1;
            sgn_b_raw_s = 1'b1;
         end
         ALU_DIV_U: op_div_s = 1'b1;
         ALU_REM_S: begin
            op_div_s    = 1'b1;
            op_rem_s    = 1'b1;
            sgn_a_raw_s = 1'b1;
            sgn_b_raw_s = 1'b1;
         end
         ALU_REM_U: begin
            op_div_s = 1'b1;
            op_rem_s = 1'b1;
         end
         default: op_mul_s = 1'b0;
      endcase
      // MULHSU forces rs1 signed and rs2 unsigned regardless of the mul op sign.
      sgn_a_s = (op_mul_s && mulhsu_i) ? 1'b1 : sgn_a_raw_s;
      sgn_b_s = (op_mul_s && mulhsu_i) ? 1'b0 : sgn_b_raw_s;
      neg_a_s = sgn_a_s & rs1_i[XLEN-1];
      neg_b_s = sgn_b_s & rs2_i[XLEN-1];
      mag_a_s = neg_a_s ? (ZERO_W - rs1_i) : rs1_i;
      mag_b_s = neg_b_s ? (ZERO_W - rs2_i) : rs2_i;
   end

`ifdef MULDIV_FAST_MUL_EN
   // Single-cycle magnitude product with sign applied afterwards.
   always_comb begin
      fast_prod_s     = {ZERO_W, mag_a_s} * {ZERO_W, mag_b_s};
      fast_prod_sgn_s = (neg_a_s ^ neg_b_s) ? ((2*XLEN)'(0) - fast_prod_s) : fast_prod_s;
      fast_res_s      = mul_hi_i ? fast_prod_sgn_s[2*XLEN-1:XLEN] : fast_prod_sgn_s[XLEN-1:0];
   end
`endif

   // One iteration of shift-add multiply and restoring divide, plus final sign fix-up.
   always_comb begin
      mul_sum_s      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      mul_prod_s     = {mul_sum_s, lo_q[XLEN-1:1]};
      mul_prod_sgn_s = neg_q ? ((2*XLEN)'(0) - mul_prod_s) : mul_prod_s;
      mul_res_s      = hi_sel_q ? mul_prod_sgn_s[2*XLEN-1:XLEN] : mul_prod_sgn_s[XLEN-1:0];
      div_rem_sh_s   = {hi_q, lo_q[XLEN-1]};
      div_diff_s     = div_rem_sh_s - {1'b0, b_q};
      div_ge_s       = ~div_diff_s[XLEN];
      div_rem_s      = div_ge_s ? div_diff_s[XLEN-1:0] : div_rem_sh_s[XLEN-1:0];
      div_quo_s      = {lo_q[XLEN-2:0], div_ge_s};
      div_pick_s     = rem_sel_q ? div_rem_s : div_quo_s;
      div_res_s      = neg_q ? (ZERO_W - div_pick_s) : div_pick_s;
   end

   // Next-state, datapath and output-register logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      b_d       = b_q;
      is_mul_d  = is_mul_q;
      hi_sel_d  = hi_sel_q;
      rem_sel_d = rem_sel_q;
      neg_d     = neg_q;
      result_d  = result_q;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid_i) begin
                  is_mul_d  = op_mul_s;
                  hi_sel_d  = mul_hi_i;
                  rem_sel_d = op_rem_s;
                  neg_d     = op_rem_s ? neg_a_s : (neg_a_s ^ neg_b_s);
                  hi_d      = ZERO_W;
                  lo_d      = mag_a_s;
                  b_d       = mag_b_s;
                  cnt_d     = CNT_LAST;
                  if (!op_mul_s && !op_div_s) begin
                     result_d = ZERO_W;
                     state_d  = ST_DONE;
                  end else if (op_div_s && (rs2_i == ZERO_W)) begin
                     result_d = op_rem_s ? rs1_i : ALL_ONES;
                     state_d  = ST_DONE;
                  end else if (op_div_s && sgn_a_s && (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES)) begin
                     result_d = op_rem_s ? ZERO_W : rs1_i;
                     state_d  = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (op_mul_s) begin
                     result_d = fast_res_s;
                     state_d  = ST_DONE;
`endif
                  end else begin
                     state_d = ST_CALC;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CALC: begin
               if (is_mul_q) begin
                  hi_d = mul_sum_s[XLEN:1];
                  lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
               end else begin
                  hi_d = div_rem_s;
                  lo_d = div_quo_s;
               end
               if (cnt_q == {CNT_W{1'b0}}) begin
                  result_d = is_mul_q ? mul_res_s : div_res_s;
                  cnt_d    = {CNT_W{1'b0}};
                  state_d  = ST_DONE;
               end else begin
                  cnt_d   = cnt_q - CNT_W'(1);
                  state_d = ST_CALC;
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         hi_q        <= ZERO_W;
         lo_q        <= ZERO_W;
         b_q         <= ZERO_W;
         is_mul_q    <= 1'b0;
         hi_sel_q    <= 1'b0;
         rem_sel_q   <= 1'b0;
         neg_q       <= 1'b0;
         result_q    <= ZERO_W;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         b_q         <= b_d;
         is_mul_q    <= is_mul_d;
         hi_sel_q    <= hi_sel_d;
         rem_sel_q   <= rem_sel_d;
         neg_q       <= neg_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed-vector bench for muldiv_iter_unit; latencies follow MULDIV_FAST_MUL_EN.
module tb_muldiv_iter_unit;
   import muldiv_iter_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   aluop_e      op_i = ALU_ADD;
   logic        mul_hi_i = 1'b0;
   logic        mulhsu_i = 1'b0;
   logic [31:0] rs1_i = 32'd0;
   logic [31:0] rs2_i = 32'd0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [31:0] result_o;

   int vec_cnt = 0;
   int err_cnt = 0;

   muldiv_iter_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .op_i(op_i), .mul_hi_i(mul_hi_i), .mulhsu_i(mulhsu_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vec_cnt++;
      if (obs !== exp_v) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Offer one op, count edges (accept edge = 1) until out_valid, check result, return to IDLE.
   task automatic run_op(input string tag, input aluop_e op, input logic hi, input logic hsu,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
      int n;
      @(negedge clk);
      op_i = op; mul_hi_i = hi; mulhsu_i = hsu; rs1_i = a; rs2_i = b;
      in_valid_i = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge clk); #1;
         in_valid_i = 1'b0;
         n++;
         if (out_valid_o) break;
      end
      chk_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk_eq(tag, result_o, exp_res);
      @(posedge clk); #1;
      chk_eq({tag, "_idle"}, {31'd0, in_ready_o}, 32'd1);
   endtask

   task automatic start_op(input aluop_e op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_i = op; mul_hi_i = 1'b0; mulhsu_i = 1'b0; rs1_i = a; rs2_i = b;
      in_valid_i = 1'b1;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
   endtask

   initial begin
      logic seen;
      int   n;
      #12;
      chk_eq("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk_eq("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk_eq("rst_result", result_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mulu_hi", ALU_MUL_U, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
      run_op("mulu_lo", ALU_MUL_U, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT);
      run_op("mulhsu_hi", ALU_MUL_S, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
      run_op("mulhsu_lo", ALU_MUL_S, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MUL_LAT);
      run_op("muls_hi", ALU_MUL_S, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
      run_op("muls_lo", ALU_MUL_S, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MUL_LAT);
      run_op("mulu_lo2", ALU_MUL_U, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MUL_LAT);
      run_op("mulu_hi2", ALU_MUL_U, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, MUL_LAT);
      run_op("muls_m3x5_lo", ALU_MUL_S, 1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, MUL_LAT);
      run_op("muls_m3x5_hi", ALU_MUL_S, 1'b1, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, MUL_LAT);

      run_op("divs_m7_2", ALU_DIV_S, 1'b0, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT);
      run_op("rems_m7_2", ALU_REM_S, 1'b0, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT);
      run_op("divs_7_m2", ALU_DIV_S, 1'b0, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
      run_op("rems_7_m2", ALU_REM_S, 1'b0, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, DIV_LAT);
      run_op("divu_7_2", ALU_DIV_U, 1'b0, 1'b0, 32'h00000007, 32'h00000002, 32'h00000003, DIV_LAT);
      run_op("remu_7_2", ALU_REM_U, 1'b0, 1'b0, 32'h00000007, 32'h00000002, 32'h00000001, DIV_LAT);
      run_op("divu_big", ALU_DIV_U, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, DIV_LAT);
      run_op("remu_big", ALU_REM_U, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, DIV_LAT);

      run_op("divu_by0", ALU_DIV_U, 1'b0, 1'b0, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1);
      run_op("remu_by0", ALU_REM_U, 1'b0, 1'b0, 32'h00000005, 32'h00000000, 32'h00000005, 1);
      run_op("divs_ovf", ALU_DIV_S, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rems_ovf", ALU_REM_S, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      run_op("unsup_op", ALU_ADD, 1'b0, 1'b0, 32'h12345678, 32'h00000001, 32'h00000000, 1);

      // Flush at CALC cycle 10.
      start_op(ALU_DIV_U, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk_eq("flush_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk_eq("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen = seen | out_valid_o;
      end
      chk_eq("flush_no_result", {31'd0, seen}, 32'd0);
      run_op("after_flush_6_3", ALU_DIV_U, 1'b0, 1'b0, 32'd6, 32'd3, 32'd2, DIV_LAT);

      // Flush in the accept cycle drops the op.
      @(negedge clk);
      op_i = ALU_DIV_U; rs1_i = 32'd9; rs2_i = 32'd0;
      in_valid_i = 1'b1; flush_i = 1'b1;
      @(posedge clk); #1;
      in_valid_i = 1'b0; flush_i = 1'b0;
      chk_eq("acc_flush_ready", {31'd0, in_ready_o}, 32'd1);
      seen = 1'b0;
      repeat (36) begin
         seen = seen | out_valid_o;
         @(posedge clk); #1;
      end
      chk_eq("acc_flush_no_result", {31'd0, seen}, 32'd0);

      // Consumer stalls 5 cycles in DONE.
      out_ready_i = 1'b0;
      start_op(ALU_DIV_U, 32'd100, 32'd7);
      n = 1;
      while (!out_valid_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk_eq("hold_lat", 32'(n), 32'(DIV_LAT));
      repeat (5) begin
         @(posedge clk); #1;
         chk_eq("hold_result", result_o, 32'd14);
         chk_eq("hold_valid", {31'd0, out_valid_o}, 32'd1);
         chk_eq("hold_in_ready", {31'd0, in_ready_o}, 32'd0);
      end
      @(negedge clk);
      out_ready_i = 1'b1;
      @(posedge clk); #1;
      chk_eq("hold_release_valid", {31'd0, out_valid_o}, 32'd0);
      chk_eq("hold_release_ready", {31'd0, in_ready_o}, 32'd1);

      // Asynchronous reset mid-CALC.
      start_op(ALU_DIV_U, 32'd50, 32'd3);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk_eq("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk_eq("midrst_result", result_o, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen = seen | out_valid_o;
      end
      chk_eq("midrst_no_result", {31'd0, seen}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst_6_3", ALU_DIV_U, 1'b0, 1'b0, 32'd6, 32'd3, 32'd2, DIV_LAT);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
